riscv_fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end replacing the bare PC register and single-cycle instruction memory path of the core top.
- Issues pipelined requests to instruction memory over a req/gnt/rvalid handshake and tracks outstanding requests.
- Buffers returned instructions with their PCs in a FIFO and presents them to decode over a valid/ready handshake.
- Supports redirects from branch/jump resolution: flushes buffered and in-flight fetches.

---
 rtl/riscv_fetch_unit.sv | 104 ++++++++++
 tb/tb_riscv_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: pipelined req/gnt/rvalid fetch with outstanding
// tracking, an instruction/PC buffer toward decode, and redirect flushing.
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h1000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    output logic                          instr_mem_req_o,
    output logic [31:0]                   instr_mem_addr_o,
    input  logic                          instr_mem_gnt_i,
    input  logic                          instr_mem_rvalid_i,
    input  logic [31:0]                   instr_mem_rd_data_i,
    input  logic                          redirect_i,
    input  logic [31:0]                   redirect_pc_i,
    output logic                          instr_valid_o,
    output logic [31:0]                   instr_o,
    output logic [31:0]                   instr_pc_o,
    input  logic                          instr_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] MAX_OUT_C = (CW+1)'(MAX_OUTSTANDING);
    localparam logic [CW:0] DEPTH_C   = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   data_mem [FIFO_DEPTH];
    logic [31:0]   pc_mem   [FIFO_DEPTH];

    logic          grant;
    logic          pop;
    logic          push;
    logic          drop;
    logic [CW-1:0] inflight;
    logic [CW-1:0] redirect_discard;
    logic [31:0]   redirect_target;

    always_comb begin
        inflight         = outstanding + discard;
        redirect_target  = {redirect_pc_i[31:2], 2'b00};
        // Count reservation: every in-flight request already owns a buffer slot
        instr_mem_req_o  = reset_n && !redirect_i
                           && ({1'b0, inflight} < MAX_OUT_C)
                           && (({1'b0, count} + {1'b0, outstanding}) < DEPTH_C);
        grant            = instr_mem_req_o && instr_mem_gnt_i;
        pop              = instr_valid_o && instr_ready_i;
        drop             = instr_mem_rvalid_i && (discard != '0);
        push             = instr_mem_rvalid_i && (discard == '0) && (outstanding != '0);
        redirect_discard = inflight - CW'(instr_mem_rvalid_i && (inflight != '0));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (redirect_i) begin
            fetch_pc    <= redirect_target;
            resp_pc     <= redirect_target;
            outstanding <= '0;
            discard     <= redirect_discard;
            count       <= '0;
            wr_ptr      <= rd_ptr;
        end else begin
            if (grant) fetch_pc <= fetch_pc + 32'd4;
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
                wr_ptr  <= wr_ptr + PW'(1);
            end
            if (pop)  rd_ptr  <= rd_ptr + PW'(1);
            if (drop) discard <= discard - CW'(1);
            outstanding <= outstanding + CW'(grant) - CW'(push);
            count       <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !redirect_i) begin
            data_mem[wr_ptr] <= instr_mem_rd_data_i;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end

    // Storage is not reset; outputs are forced to zero whenever the buffer is empty
    assign instr_valid_o    = (count != '0);
    assign instr_o          = instr_valid_o ? data_mem[rd_ptr] : '0;
    assign instr_pc_o       = instr_valid_o ? pc_mem[rd_ptr] : '0;
    assign instr_mem_addr_o = fetch_pc;
    assign fifo_count_o     = count;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Self-checking bench for riscv_fetch_unit: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_riscv_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h1000;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req;
    logic [31:0] addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rd_data = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        ready = 1'b0;
    logic [2:0]  count;

    riscv_fetch_unit #(
        .RESET_PC(RESET_PC),
        .FIFO_DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .instr_mem_req_o(req),
        .instr_mem_addr_o(addr),
        .instr_mem_gnt_i(gnt),
        .instr_mem_rvalid_i(rvalid),
        .instr_mem_rd_data_i(rd_data),
        .redirect_i(redirect),
        .redirect_pc_i(redirect_pc),
        .instr_valid_o(valid),
        .instr_o(instr),
        .instr_pc_o(instr_pc),
        .instr_ready_i(ready),
        .fifo_count_o(count)
    );

    always #5 clk = ~clk;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    // Reference model: buffer as a queue of {pc, data}, plus counters
    logic [63:0] mq[$];
    logic [31:0] pend[$];
    logic [31:0] m_fetch;
    logic [31:0] m_resp;
    int          m_out;
    int          m_disc;
    bit          resp_en = 1'b1;
    bit          gnt_en  = 1'b1;

    function automatic bit exp_req();
        return reset_n && !redirect && ((m_out + m_disc) < MAXO)
               && ((mq.size() + m_out) < DEPTH);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_fetch = RESET_PC;
        m_resp  = RESET_PC;
        m_out   = 0;
        m_disc  = 0;
        mq.delete();
        pend.delete();
    endtask

    task automatic model_step();
        int  old_out  = m_out;
        int  old_disc = m_disc;
        bit  g        = exp_req() && gnt;
        bit  p        = (mq.size() > 0) && ready;
        if (g) pend.push_back(m_fetch);
        if (redirect) begin
            m_fetch = {redirect_pc[31:2], 2'b00};
            m_resp  = m_fetch;
            mq.delete();
            m_disc  = old_out + old_disc - ((rvalid && (old_out + old_disc) > 0) ? 1 : 0);
            m_out   = 0;
        end else begin
            if (p) void'(mq.pop_front());
            if (rvalid) begin
                if (old_disc > 0) m_disc--;
                else if (old_out > 0) begin
                    mq.push_back({m_resp, rd_data});
                    m_resp += 32'd4;
                    m_out--;
                end
            end
            if (g) begin
                m_fetch += 32'd4;
                m_out++;
            end
        end
    endtask

    // One clock: update the model at the edge, then drive the memory side
    task automatic cycle();
        @(posedge clk);
        if (reset_n) model_step();
        #1;
        gnt = gnt_en;
        if (resp_en && pend.size() > 0) begin
            rvalid  = 1'b1;
            rd_data = ~pend.pop_front();
        end else begin
            rvalid  = 1'b0;
            rd_data = '0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset(input bit stray);
        reset_n  = 1'b0;
        redirect = 1'b0;
        model_reset();
        run(2);
        reset_n = 1'b1;
        if (stray) begin
            rvalid  = 1'b1;
            rd_data = 32'hDEAD_BEEF;
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_req",   32'(req),   32'd0);
            check("rst_addr",  addr,       RESET_PC);
            check("rst_valid", 32'(valid), 32'd0);
            check("rst_count", 32'(count), 32'd0);
            check("rst_instr", instr,      32'd0);
            check("rst_pc",    instr_pc,   32'd0);
        end else begin
            check("req",   32'(req),   32'(exp_req()));
            check("addr",  addr,       m_fetch);
            check("valid", 32'(valid), 32'(mq.size() > 0));
            check("count", 32'(count), 32'(mq.size()));
            if (mq.size() > 0) begin
                check("instr",    instr,    mq[0][31:0]);
                check("instr_pc", instr_pc, mq[0][63:32]);
            end
        end
    end

    initial begin
        model_reset();
        // Streaming: gnt tied high, response one cycle after grant, ready high
        ready = 1'b1;
        run(2);
        reset_n = 1'b1;
        #1;
        check("t1_req", 32'(req), 32'd1);
        check("t1_addr", addr, 32'h0000_1000);
        run(2);
        #1;
        check("t1_pc", instr_pc, 32'h0000_1000);
        check("t1_instr", instr, 32'hFFFF_EFFF);
        run(10);

        // Backpressure fills the buffer and stalls fetching
        ready = 1'b0;
        do_reset(1'b0);
        run(8);
        #1;
        check("t2_count", 32'(count), 32'd4);
        check("t2_req", 32'(req), 32'd0);
        check("t2_pc", instr_pc, 32'h0000_1000);
        ready = 1'b1;
        run(1);
        #1;
        check("t2_pc_next", instr_pc, 32'h0000_1004);
        run(8);

        // Redirect with two outstanding and two buffered
        ready = 1'b0;
        resp_en = 1'b1;
        do_reset(1'b0);
        run(2);
        resp_en = 1'b0;
        run(2);
        redirect = 1'b1;
        redirect_pc = 32'h0000_2002;
        cycle();
        redirect = 1'b0;
        #1;
        check("t3_count", 32'(count), 32'd0);
        check("t3_valid", 32'(valid), 32'd0);
        check("t3_addr", addr, 32'h0000_2000);
        check("t3_req", 32'(req), 32'd0);
        resp_en = 1'b1;
        run(5);
        #1;
        check("t3_pc", instr_pc, 32'h0000_2000);
        check("t3_instr", instr, 32'hFFFF_DFFF);

        // Redirect coinciding with a response and a pop, one outstanding
        ready = 1'b1;
        run(6);
        redirect = 1'b1;
        redirect_pc = 32'h0000_3000;
        cycle();
        redirect = 1'b0;
        #1;
        check("t4_req", 32'(req), 32'd1);
        check("t4_addr", addr, 32'h0000_3000);
        run(10);

        // Delayed grant holds request and address
        gnt_en = 1'b0;
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_hold_req", 32'(req), 32'd1);
            check("t5_hold_addr", addr, 32'h0000_1000);
            cycle();
        end
        gnt_en = 1'b1;
        gnt = 1'b1;
        cycle();
        #1;
        check("t5_addr_after", addr, 32'h0000_1004);
        run(6);

        // Address wrap, then reset mid-burst followed by a stray response
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        cycle();
        redirect = 1'b0;
        #1;
        check("t6_addr_top", addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 10 && m_fetch == 32'hFFFF_FFFC; i++) cycle();
        #1;
        check("t6_addr_wrap", addr, 32'h0000_0000);
        run(3);
        do_reset(1'b1);
        run(2);
        #1;
        check("t6_valid", 32'(valid), 32'd1);
        check("t6_pc", instr_pc, 32'h0000_1000);
        check("t6_instr", instr, 32'hFFFF_EFFF);
        check("t6_count", 32'(count), 32'd1);
        run(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
